// File: rtl/boot_pkg.sv
// Shared types and frame constants for the IMEM boot loader.
// Optional warm reload in RUN is enabled by defining BOOT_RELOAD_EN.
package boot_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN0  = 3'd1,
        LEN1  = 3'd2,
        DATA  = 3'd3,
        CSUM  = 3'd4,
        RUN   = 3'd5,
        ERROR = 3'd6
    } boot_state_e;

    localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
    localparam int unsigned LEN_W         = 16;
    localparam int unsigned LANE_W        = 2;

endpackage

// File: rtl/rx_word_packer.sv
// Packs incoming bytes into 32-bit little-endian words; pulses word_valid the
// cycle after the fourth byte of a word is accepted.
module rx_word_packer
    import boot_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic [LANE_W-1:0] lane,
    output logic              word_valid,
    output logic [31:0]       word
);

    logic [LANE_W-1:0] lane_q;
    logic [23:0]       asm_q;
    logic [31:0]       word_q;
    logic              valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q  <= '0;
            asm_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (clear) begin
                lane_q <= '0;
            end else if (byte_valid) begin
                if (lane_q == '1) begin
                    word_q  <= {byte_data, asm_q};
                    valid_q <= 1'b1;
                    lane_q  <= '0;
                end else begin
                    asm_q[lane_q*8 +: 8] <= byte_data;
                    lane_q               <= lane_q + 1'b1;
                end
            end
        end
    end

    assign lane       = lane_q;
    assign word_valid = valid_q;
    assign word       = word_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Boot sequencer: holds the core in reset, loads a framed image into IMEM,
// verifies length and checksum, then releases the core. Macro: BOOT_RELOAD_EN.
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned MAX_WORDS = 1024,
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

    boot_state_e       state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_n, wcnt_q;
    logic [7:0]        csum_q;
    logic              rx_ready_q, busy_q, done_q, err_q;
    logic              accept, is_sync, start, rdy_d;
    logic [LANE_W-1:0] lane;
    logic              word_valid;
    logic [31:0]       word;

    assign accept  = rx_valid && rx_ready_q;
    assign is_sync = (rx_data == SYNC_BYTE);
    assign len_n   = {rx_data, len_q[7:0]};
    // Entering LEN0 from anywhere else marks the start of a new frame.
    assign start   = (state_d == LEN0) && (state_q != LEN0);

    rx_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (state_q != DATA),
        .byte_valid (accept && (state_q == DATA)),
        .byte_data  (rx_data),
        .lane       (lane),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (accept && is_sync) state_d = LEN0;
            LEN0:  if (accept) state_d = LEN1;
            LEN1: begin
                if (accept) begin
                    if (32'(len_n) > MAX_WORDS) state_d = ERROR;
                    else if (len_n == '0)       state_d = CSUM;
                    else                        state_d = DATA;
                end
            end
            DATA: begin
                if (accept && (lane == '1) && (wcnt_q == len_q - LEN_W'(1))) state_d = CSUM;
            end
            CSUM:  if (accept) state_d = (rx_data == csum_q) ? RUN : ERROR;
`ifdef BOOT_RELOAD_EN
            RUN:   if (accept && is_sync) state_d = LEN0;
`else
            RUN:   state_d = RUN;
`endif
            ERROR: if (accept && is_sync) state_d = LEN0;
            default: state_d = IDLE;
        endcase
    end

`ifdef BOOT_RELOAD_EN
    assign rdy_d = 1'b1;
`else
    assign rdy_d = (state_d != RUN);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            len_q      <= '0;
            wcnt_q     <= '0;
            csum_q     <= '0;
            rx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start) begin
                csum_q <= '0;
                wcnt_q <= '0;
            end else begin
                if (accept && (state_q inside {LEN0, LEN1, DATA})) csum_q <= csum_q ^ rx_data;
                if (word_valid) wcnt_q <= wcnt_q + LEN_W'(1);
            end
            if (accept && (state_q == LEN0)) len_q[7:0]  <= rx_data;
            if (accept && (state_q == LEN1)) len_q[15:8] <= rx_data;
            // Status outputs follow the next state so they change on the same edge.
            rx_ready_q <= rdy_d;
            busy_q     <= state_d inside {LEN0, LEN1, DATA, CSUM};
            done_q     <= (state_d == RUN);
            err_q      <= (state_d == ERROR);
        end
    end

    assign rx_ready   = rx_ready_q;
    assign imem_we    = word_valid;
    assign imem_waddr = wcnt_q[ADDR_W-1:0];
    assign imem_wdata = word;
    assign core_rst_n = done_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected IMEM writes are queued by
// the stimulus and checked by an independent monitor.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready, imem_we, core_rst_n, busy, done, err;
    logic [9:0]  imem_waddr;
    logic [31:0] imem_wdata;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    logic [7:0] good_frame [12] = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                                    8'h13, 8'h01, 8'hA0, 8'h00, 8'h73};

    imem_boot_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .core_rst_n (core_rst_n),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    // Monitor: every write the DUT presents must match the head of the queue.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n === 1'b1 && imem_we === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, want no write",
                         imem_waddr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (imem_waddr !== e.addr || imem_wdata !== e.data) begin
                    bad++;
                    $display("FAIL imem_write: got addr=%0d data=%h, want addr=%0d data=%h",
                             imem_waddr, imem_wdata, e.addr, e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rx_ready"},   32'(rx_ready),   32'd0);
        check({tag, "_imem_we"},    32'(imem_we),    32'd0);
        check({tag, "_imem_waddr"}, 32'(imem_waddr), 32'd0);
        check({tag, "_imem_wdata"}, imem_wdata,      32'd0);
        check({tag, "_core_rst_n"}, 32'(core_rst_n), 32'd0);
        check({tag, "_busy"},       32'(busy),       32'd0);
        check({tag, "_done"},       32'(done),       32'd0);
        check({tag, "_err"},        32'(err),        32'd0);
    endtask

    task automatic apply_reset();
        rx_valid = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Idle for gap cycles, then hand one byte over; returns 1 ns after the accepting edge.
    task automatic send(input logic [7:0] b, input int gap);
        int n;
        rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        n = 0;
        while (rx_ready !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (rx_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL rx_ready_wait: got %b, want 1", rx_ready);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic push_good_writes();
        exp_q.push_back('{addr: 10'd0, data: 32'h0050_0093});
        exp_q.push_back('{addr: 10'd1, data: 32'h00A0_0113});
    endtask

    task automatic send_good(input int data_gap);
        push_good_writes();
        for (int i = 0; i < 12; i++) send(good_frame[i], (i >= 3 && i <= 10) ? data_gap : 0);
    endtask

    task automatic check_running(input string tag);
        logic exp_rdy;
`ifdef BOOT_RELOAD_EN
        exp_rdy = 1'b1;
`else
        exp_rdy = 1'b0;
`endif
        check({tag, "_done"},       32'(done),       32'd1);
        check({tag, "_core_rst_n"}, 32'(core_rst_n), 32'd1);
        check({tag, "_err"},        32'(err),        32'd0);
        check({tag, "_busy"},       32'(busy),       32'd0);
        check({tag, "_rx_ready"},   32'(rx_ready),   32'(exp_rdy));
        check({tag, "_pending"},    32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        // Reset values while held in reset
        repeat (2) @(posedge clk);
        #1 check_reset_vals("reset");
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 check("idle_rx_ready", 32'(rx_ready), 32'd1);

        // Good load
        send_good(0);
        check_running("good");

        // Bad checksum, then recovery with a correct frame
        apply_reset();
        push_good_writes();
        for (int i = 0; i < 11; i++) send(good_frame[i], 0);
        send(8'h74, 0);
        check("badcs_err",        32'(err),        32'd1);
        check("badcs_done",       32'(done),       32'd0);
        check("badcs_core_rst_n", 32'(core_rst_n), 32'd0);
        check("badcs_busy",       32'(busy),       32'd0);
        check("badcs_pending",    32'(exp_q.size()), 32'd0);
        send_good(0);
        check_running("recover");

        // Length overflow: N = 1025
        apply_reset();
        send(8'hA5, 0);
        send(8'h01, 0);
        send(8'h04, 0);
        check("ovf_err",  32'(err),  32'd1);
        check("ovf_busy", 32'(busy), 32'd0);
        send(8'h93, 0);
        send(8'h00, 0);
        send(8'h50, 0);
        check("ovf_err_held", 32'(err), 32'd1);
        send_good(0);
        check_running("ovf_recover");

        // Garbage, then the good frame with 3-cycle gaps between data bytes
        apply_reset();
        send(8'h00, 0);
        send(8'hFF, 0);
        send(8'h3C, 0);
        check("garbage_busy", 32'(busy), 32'd0);
        send_good(3);
        check_running("gaps");

        // Empty image
        apply_reset();
        send(8'hA5, 0);
        send(8'h00, 0);
        check("empty_busy", 32'(busy), 32'd1);
        send(8'h00, 0);
        send(8'h00, 0);
        check_running("empty");

        // Reset in the middle of word 0
        apply_reset();
        for (int i = 0; i < 6; i++) send(good_frame[i], 0);
        rst_n = 1'b0;
        #1 check_reset_vals("midrst");
        repeat (2) @(posedge clk);
        #1 check("midrst_we_held", 32'(imem_we), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_good(0);
        check_running("after_midrst");

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Boot-time sequencer for the single-cycle RISC-V core.
- Holds the core in reset, receives a framed byte stream, packs bytes into 32-bit little-endian words and writes them into IMEM through its write port.
- Checks length and checksum, then releases the core so the PC starts at 0.
- Sits between the external byte source (UART RX or bench) and the core's IMEM write port and core reset.

Parameters:
- ADDR_W, 10, IMEM word-address width. IMEM byte address = imem_waddr << 2.
- MAX_WORDS, 1024, largest accepted word count (must be ≤ 2**ADDR_W).
- SYNC_BYTE, 8'hA5, frame start byte.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- rx_valid  input  1  byte available on rx_data
- rx_data  input  8  incoming byte
- rx_ready  output  1  byte accepted when rx_valid && rx_ready
- imem_we  output  1  one-cycle IMEM write strobe
- imem_waddr  output  ADDR_W  IMEM word address
- imem_wdata  output  32  IMEM write data
- core_rst_n  output  1  core reset, active-low; 0 while loading
- busy  output  1  frame in progress (LEN0..CSUM)
- done  output  1  image loaded and verified; core running
- err  output  1  sticky frame error

Behaviour:
- Reset values: rx_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, core_rst_n=0, busy=0, done=0, err=0. FSM enters IDLE.
- Frame format, in order:
  - SYNC_BYTE.
  - N as 2 bytes, low byte first.
  - N×4 data bytes, little-endian per word.
  - 1 checksum byte = XOR of the two N bytes and all data bytes.
- FSM states: IDLE, LEN0, LEN1, DATA, CSUM, RUN, ERROR.
  - IDLE: rx_ready=1. Non-sync bytes are discarded. SYNC_BYTE -> LEN0, clears the checksum accumulator, sets busy=1.
  - LEN0: latch N[7:0] -> LEN1.
  - LEN1: latch N[15:8].
    - N > MAX_WORDS -> ERROR; no IMEM writes occur.
    - N == 0 -> CSUM.
    - Otherwise -> DATA, with word counter=0 and byte lane=0.
  - DATA: byte k of a word goes to bits [8k+7:8k]. When the 4th byte is accepted, the next cycle has imem_we=1, imem_waddr=word counter and imem_wdata=assembled word. The word counter then increments. After word N-1 -> CSUM.
  - CSUM: compare the received byte with the accumulator.
    - Match -> RUN. The next cycle has core_rst_n=1, done=1, busy=0.
    - Mismatch -> ERROR.
  - RUN: rx_ready=0. Terminal until rst_n (see Optional Feature).
  - ERROR: err=1, busy=0, core_rst_n=0, rx_ready=1. A SYNC_BYTE clears err and goes to LEN0 (re-sync). Other bytes are discarded.
- Latency: 1 byte per cycle maximum. rx_valid may drop between bytes; no state change on idle cycles.
- The last IMEM write always completes at least one cycle before core_rst_n rises.
- imem_we is never asserted outside DATA, nor for a partial word.
- Reset mid-frame: asynchronous return to reset values. The partial word is discarded and no write is issued. imem_waddr restarts at 0 on the next frame.
- imem_waddr wraps modulo 2**ADDR_W, but MAX_WORDS bounds it, so wrap is unreachable when MAX_WORDS ≤ 2**ADDR_W.

Optional Feature:
- Macro: BOOT_RELOAD_EN.
- Defined: in RUN, rx_ready=1. A received SYNC_BYTE drops core_rst_n to 0 and done to 0 on the next cycle, then the FSM enters LEN0 (warm reload). Non-sync bytes in RUN are discarded.
- Undefined: RUN is terminal, rx_ready=0 in RUN, and rx bytes are never consumed.

Decomposition:
- Package boot_pkg holds:
  - boot_state_e enum (IDLE..ERROR).
  - Default SYNC_BYTE constant.
  - Frame-field width constants (LEN_W=16, LANE_W=2).
- Sub-module rx_word_packer: byte-lane counter plus 32-bit shift/assembly register. Interface: byte-valid, byte, and clear in; word_valid pulse and word out.
- FSM, counters, checksum and output registers stay in imem_boot_loader.

Test Plan:
- Good load: A5 02 00 93 00 50 00 13 01 A0 00 73 -> imem_we at waddr 0 with wdata 32'h00500093, then at waddr 1 with 32'h00A00113. Then core_rst_n=1 and done=1; err=0.
- Bad checksum: same frame with last byte 74 -> both writes occur, err=1, core_rst_n stays 0, done=0. A following correct frame recovers and reaches done=1.
- Length overflow: A5 01 04 (N=1025) -> err=1 after the 3rd byte, no imem_we, and later bytes are ignored until the next A5.
- Garbage and gaps: 00 FF 3C then the good frame, with rx_valid deasserted for 3 cycles between data bytes -> result identical to the good-load scenario.
- Empty image: A5 00 00 00 -> no imem_we, and done=1 plus core_rst_n=1 one cycle after the checksum byte.
- Reset mid-load: rst_n pulsed low after 3 data bytes of word 0 -> all outputs return to reset values with no write. A full good frame afterwards loads from waddr 0.
